// File: rtl/moka_rv32i_sc_commit_tracer_if.sv
// moka_rv32i_sc_commit_tracer_if
//   Commit-trace record stream from the tracer to its consumer (checker,
//   scoreboard or debug UART). The master drives one record per handshake
//   (trace_valid & trace_ready). The slave drives only trace_ready.
//   Signals:
//     trace_valid                       head record is valid
//     trace_ready                       consumer accepts the head record
//     trace_seq                         retirement sequence number
//     trace_pc/trace_pc_next/trace_instr
//     trace_rd_wr/trace_rd/trace_rd_data
//     trace_mem_wr/trace_mem_addr/trace_mem_data
interface moka_rv32i_sc_commit_tracer_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  trace_valid;
  logic                  trace_ready;
  logic [31:0]           trace_seq;
  logic [DATA_WIDTH-1:0] trace_pc;
  logic [DATA_WIDTH-1:0] trace_pc_next;
  logic [DATA_WIDTH-1:0] trace_instr;
  logic                  trace_rd_wr;
  logic [4:0]            trace_rd;
  logic [DATA_WIDTH-1:0] trace_rd_data;
  logic                  trace_mem_wr;
  logic [DATA_WIDTH-1:0] trace_mem_addr;
  logic [DATA_WIDTH-1:0] trace_mem_data;

  modport master (
    output trace_valid, trace_seq, trace_pc, trace_pc_next, trace_instr,
           trace_rd_wr, trace_rd, trace_rd_data,
           trace_mem_wr, trace_mem_addr, trace_mem_data,
    input  trace_ready
  );

  modport slave (
    input  trace_valid, trace_seq, trace_pc, trace_pc_next, trace_instr,
           trace_rd_wr, trace_rd, trace_rd_data,
           trace_mem_wr, trace_mem_addr, trace_mem_data,
    output trace_ready
  );
endinterface

// File: rtl/moka_rv32i_sc_commit_tracer.sv
// moka_rv32i_sc_commit_tracer
//   Snapshots the architectural effects of each instruction retired by the
//   single-cycle RV32I core into a FIFO. The records are drained over a
//   valid/ready stream. The core is never stalled. When the FIFO is full,
//   records are dropped, the sticky overflow flag is set and the drop
//   counter (saturating) is incremented.
//   Ports:
//     clk, rst        core clock, asynchronous active-high reset
//     trace_en        capture enable (disabled retirements are not drops)
//     flush           synchronous clear of FIFO, seq, drop_cnt, overflow
//     retire, pc, pc_next, instruction, RegWrite, rd, WD3,
//     MemWrite, ALUResult, RD2      core probe inputs
//     trace           record stream (master side of the interface)
//     level           FIFO occupancy
//     overflow        sticky: at least one record dropped
//     drop_cnt        dropped-record count, saturates at all-ones
//   Configuration macro: MOKA_TRACE_MEM_EN. When defined, store fields are
//   kept per entry. When undefined, they are not stored and read as 0.
module moka_rv32i_sc_commit_tracer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          trace_en,
  input  logic                          flush,
  input  logic                          retire,
  input  logic [DATA_WIDTH-1:0]         pc,
  input  logic [DATA_WIDTH-1:0]         pc_next,
  input  logic [DATA_WIDTH-1:0]         instruction,
  input  logic                          RegWrite,
  input  logic [4:0]                    rd,
  input  logic [DATA_WIDTH-1:0]         WD3,
  input  logic                          MemWrite,
  input  logic [DATA_WIDTH-1:0]         ALUResult,
  input  logic [DATA_WIDTH-1:0]         RD2,
  moka_rv32i_sc_commit_tracer_if.master trace,
  output logic [$clog2(DEPTH):0]        level,
  output logic                          overflow,
  output logic [CNT_WIDTH-1:0]          drop_cnt
);

  localparam int AW = $clog2(DEPTH);

  typedef logic [AW-1:0]        ptr_t;
  typedef logic [AW:0]          lvl_t;
  typedef logic [CNT_WIDTH-1:0] cnt_t;

  typedef struct packed {
    logic [31:0]           seq;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] pc_next;
    logic [DATA_WIDTH-1:0] instr;
    logic                  rd_wr;
    logic [4:0]            rd;
    logic [DATA_WIDTH-1:0] rd_data;
`ifdef MOKA_TRACE_MEM_EN
    logic                  mem_wr;
    logic [DATA_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data;
`endif
  } entry_t;

  entry_t      mem [DEPTH];
  entry_t      wr_entry;
  entry_t      head;
  ptr_t        wr_ptr;
  ptr_t        rd_ptr;
  logic [31:0] seq;
  logic        valid;
  logic        push;
  logic        pop;
  logic        full;
  logic        accept;

`ifndef MOKA_TRACE_MEM_EN
  logic unused_mem;
  assign unused_mem = ^{MemWrite, ALUResult, RD2};
`endif

  assign valid  = (level != '0);
  assign push   = trace_en & retire;
  assign pop    = valid & trace.trace_ready;
  assign full   = (level == lvl_t'(DEPTH));
  // A full FIFO still takes the new record when the head leaves in the same cycle.
  assign accept = push & (~full | pop);

  always_comb begin
    wr_entry          = '0;
    wr_entry.seq      = seq;
    wr_entry.pc       = pc;
    wr_entry.pc_next  = pc_next;
    wr_entry.instr    = instruction;
    wr_entry.rd_wr    = RegWrite & (rd != 5'd0);
    wr_entry.rd       = rd;
    wr_entry.rd_data  = WD3;
`ifdef MOKA_TRACE_MEM_EN
    wr_entry.mem_wr   = MemWrite;
    wr_entry.mem_addr = ALUResult;
    wr_entry.mem_data = RD2;
`endif
  end

  // Storage carries no reset. Occupancy gates every read, so stale contents never reach the outputs.
  always_ff @(posedge clk) begin
    if (~flush & accept)
      mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      seq      <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      seq      <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (push)
        seq <= seq + 32'd1;
      if (accept)
        wr_ptr <= wr_ptr + ptr_t'(1);
      if (pop)
        rd_ptr <= rd_ptr + ptr_t'(1);
      case ({accept, pop})
        2'b10:   level <= level + lvl_t'(1);
        2'b01:   level <= level - lvl_t'(1);
        default: level <= level;
      endcase
      if (push & ~accept) begin
        overflow <= 1'b1;
        if (drop_cnt != '1)
          drop_cnt <= drop_cnt + cnt_t'(1);
      end
    end
  end

  always_comb begin
    head = '0;
    if (valid)
      head = mem[rd_ptr];
  end

  assign trace.trace_valid   = valid;
  assign trace.trace_seq     = head.seq;
  assign trace.trace_pc      = head.pc;
  assign trace.trace_pc_next = head.pc_next;
  assign trace.trace_instr   = head.instr;
  assign trace.trace_rd_wr   = head.rd_wr;
  assign trace.trace_rd      = head.rd;
  assign trace.trace_rd_data = head.rd_data;
`ifdef MOKA_TRACE_MEM_EN
  assign trace.trace_mem_wr   = head.mem_wr;
  assign trace.trace_mem_addr = head.mem_addr;
  assign trace.trace_mem_data = head.mem_data;
`else
  assign trace.trace_mem_wr   = 1'b0;
  assign trace.trace_mem_addr = '0;
  assign trace.trace_mem_data = '0;
`endif

endmodule

// File: tb/tb_moka_rv32i_sc_commit_tracer.sv
module tb_moka_rv32i_sc_commit_tracer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        trace_en = 1'b1;
  logic        flush = 1'b0;
  logic        retire = 1'b0;
  logic [31:0] pc = '0, pc_next = '0, instruction = '0;
  logic        RegWrite = 1'b0;
  logic [4:0]  rd = '0;
  logic [31:0] WD3 = '0;
  logic        MemWrite = 1'b0;
  logic [31:0] ALUResult = '0, RD2 = '0;
  logic [4:0]  level;
  logic        overflow;
  logic [15:0] drop_cnt;

  moka_rv32i_sc_commit_tracer_if #(.DATA_WIDTH(32)) trace_if ();

  moka_rv32i_sc_commit_tracer #(
    .DATA_WIDTH(32),
    .DEPTH(16),
    .CNT_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst), .trace_en(trace_en), .flush(flush), .retire(retire),
    .pc(pc), .pc_next(pc_next), .instruction(instruction),
    .RegWrite(RegWrite), .rd(rd), .WD3(WD3),
    .MemWrite(MemWrite), .ALUResult(ALUResult), .RD2(RD2),
    .trace(trace_if),
    .level(level), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] seq;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] instr;
    logic        rd_wr;
    logic [4:0]  rd;
    logic [31:0] rd_data;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
  } rec_t;

  rec_t        exp_q[$];
  logic [31:0] exp_seq = '0;
  int          vectors = 0;
  int          miscompares = 0;
  logic        hold_chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one retirement for one cycle and queues the expected record when it should be accepted.
  task automatic retire_one(input logic [31:0] p, input logic [31:0] ins,
                            input logic rw, input logic [4:0] r, input logic [31:0] wd,
                            input logic mw, input logic [31:0] ma, input logic [31:0] md,
                            input logic rw_exp, input bit accept);
    rec_t e;
    pc = p; pc_next = p + 32'd4; instruction = ins;
    RegWrite = rw; rd = r; WD3 = wd;
    MemWrite = mw; ALUResult = ma; RD2 = md;
    retire = 1'b1;
    e.seq = exp_seq; e.pc = p; e.pc_next = p + 32'd4; e.instr = ins;
    e.rd_wr = rw_exp; e.rd = r; e.rd_data = wd;
`ifdef MOKA_TRACE_MEM_EN
    e.mem_wr = mw; e.mem_addr = ma; e.mem_data = md;
`else
    e.mem_wr = 1'b0; e.mem_addr = '0; e.mem_data = '0;
`endif
    if (accept) exp_q.push_back(e);
    exp_seq = exp_seq + 32'd1;
    @(posedge clk); #1;
    retire = 1'b0;
  endtask

  task automatic simple(input logic [31:0] n, input bit accept);
    retire_one(32'h1000 + 4 * n, 32'h00000013 | (n << 20), 1'b1, 5'd3, n, 1'b0, '0, '0, 1'b1, accept);
  endtask

  task automatic drain(input int budget);
    trace_if.trace_ready = 1'b1;
    for (int i = 0; i < budget && trace_if.trace_valid; i++) begin
      @(posedge clk); #1;
    end
    chk("drain_valid_low", {31'd0, trace_if.trace_valid}, 32'd0);
    chk("drain_queue_empty", exp_q.size(), 32'd0);
  endtask

  // Monitor: compares each record the consumer accepts against the scoreboard head.
  logic        stalled = 1'b0;
  logic [31:0] held_seq, held_pc, held_instr;
  always @(negedge clk) begin
    if (!rst) begin
      if (hold_chk_en && stalled && trace_if.trace_valid) begin
        chk("hold_seq", trace_if.trace_seq, held_seq);
        chk("hold_pc", trace_if.trace_pc, held_pc);
        chk("hold_instr", trace_if.trace_instr, held_instr);
      end
      stalled    = trace_if.trace_valid & ~trace_if.trace_ready & ~flush;
      held_seq   = trace_if.trace_seq;
      held_pc    = trace_if.trace_pc;
      held_instr = trace_if.trace_instr;
      if (trace_if.trace_valid && trace_if.trace_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_record: got seq 0x%08h expected no record", trace_if.trace_seq);
        end else begin
          rec_t e;
          e = exp_q.pop_front();
          chk("rec_seq", trace_if.trace_seq, e.seq);
          chk("rec_pc", trace_if.trace_pc, e.pc);
          chk("rec_pc_next", trace_if.trace_pc_next, e.pc_next);
          chk("rec_instr", trace_if.trace_instr, e.instr);
          chk("rec_rd_wr", {31'd0, trace_if.trace_rd_wr}, {31'd0, e.rd_wr});
          chk("rec_rd", {27'd0, trace_if.trace_rd}, {27'd0, e.rd});
          chk("rec_rd_data", trace_if.trace_rd_data, e.rd_data);
          chk("rec_mem_wr", {31'd0, trace_if.trace_mem_wr}, {31'd0, e.mem_wr});
          chk("rec_mem_addr", trace_if.trace_mem_addr, e.mem_addr);
          chk("rec_mem_data", trace_if.trace_mem_data, e.mem_data);
        end
      end
    end else begin
      stalled = 1'b0;
    end
  end

  initial begin
    trace_if.trace_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_valid", {31'd0, trace_if.trace_valid}, 32'd0);
    chk("rst_level", {27'd0, level}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
    chk("rst_seq", trace_if.trace_seq, 32'd0);
    chk("rst_pc", trace_if.trace_pc, 32'd0);

    // Single retire: addi x1, x0, 5
    trace_if.trace_ready = 1'b1;
    retire_one(32'h0, 32'h00500093, 1'b1, 5'd1, 32'd5, 1'b0, '0, '0, 1'b1, 1'b1);
    chk("single_valid", {31'd0, trace_if.trace_valid}, 32'd1);
    chk("single_level", {27'd0, level}, 32'd1);
    @(posedge clk); #1;
    chk("single_level_after_pop", {27'd0, level}, 32'd0);

    // Write to x0, then a store
    retire_one(32'h4, 32'h07700013, 1'b1, 5'd0, 32'h77, 1'b0, '0, '0, 1'b0, 1'b1);
    retire_one(32'h8, 32'h0020a023, 1'b0, 5'd0, 32'h0, 1'b1, 32'h100, 32'hdeadbeef, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1 chk("store_level", {27'd0, level}, 32'd0);

    // Overflow: 20 retires with no consumer
    trace_if.trace_ready = 1'b0;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    exp_seq = '0;
    for (int i = 0; i < 20; i++) simple(i, i < 16);
    chk("ovf_level", {27'd0, level}, 32'd16);
    chk("ovf_flag", {31'd0, overflow}, 32'd1);
    chk("ovf_drop_cnt", {16'd0, drop_cnt}, 32'd4);
    drain(40);

    // Full FIFO with simultaneous retire and pop
    trace_if.trace_ready = 1'b0;
    for (int i = 0; i < 16; i++) simple(100 + i, 1'b1);
    chk("full_level", {27'd0, level}, 32'd16);
    trace_if.trace_ready = 1'b1;
    simple(200, 1'b1);
    chk("full_pushpop_level", {27'd0, level}, 32'd16);
    chk("full_pushpop_drop_cnt", {16'd0, drop_cnt}, 32'd4);
    drain(40);

    // Backpressure: ready toggles 1010... during 8 retires
    hold_chk_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      trace_if.trace_ready = (i % 2 == 0);
      simple(300 + i, 1'b1);
    end
    drain(40);
    hold_chk_en = 1'b0;

    // Flush with level 5 plus a simultaneous retire
    trace_if.trace_ready = 1'b0;
    for (int i = 0; i < 5; i++) simple(400 + i, 1'b1);
    chk("pre_flush_level", {27'd0, level}, 32'd5);
    flush = 1'b1;
    retire_one(32'h5000, 32'h00000013, 1'b1, 5'd4, 32'h9, 1'b0, '0, '0, 1'b1, 1'b0);
    flush = 1'b0;
    exp_q.delete();
    exp_seq = '0;
    chk("flush_level", {27'd0, level}, 32'd0);
    chk("flush_drop_cnt", {16'd0, drop_cnt}, 32'd0);
    chk("flush_overflow", {31'd0, overflow}, 32'd0);
    chk("flush_valid", {31'd0, trace_if.trace_valid}, 32'd0);
    trace_if.trace_ready = 1'b1;
    simple(500, 1'b1);
    drain(10);

    // Asynchronous reset pulse between edges
    trace_if.trace_ready = 1'b0;
    simple(600, 1'b1);
    simple(601, 1'b1);
    chk("pre_rst_valid", {31'd0, trace_if.trace_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", {31'd0, trace_if.trace_valid}, 32'd0);
    chk("async_rst_level", {27'd0, level}, 32'd0);
    exp_q.delete();
    exp_seq = '0;
    #2 rst = 1'b0;
    @(posedge clk); #1;
    trace_if.trace_ready = 1'b1;
    simple(700, 1'b1);
    drain(10);

    repeat (2) @(posedge clk);
    #1 chk("final_level", {27'd0, level}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/moka_rv32i_sc_commit_tracer.md
# moka_rv32i_sc_commit_tracer

Commit-trace capture stage downstream of the single-cycle RV32I core's internal probe signals. Each cycle the core retires an instruction, the block snapshots the architectural effects: PC, instruction word, register write-back and optional store. It queues one record per instruction in a FIFO and drains the records over a valid/ready stream to a checker, scoreboard or debug UART. Records are dropped and counted on overflow; the core is never stalled.

## Interface
- DATA_WIDTH, 32, datapath width; must be 32.
- DEPTH, 16, FIFO entries; power of two, ≥2.
- CNT_WIDTH, 16, width of the drop counter.
- clk  in  1  Core clock; all state updates on the rising edge.
- rst  in  1  Asynchronous, active-high reset.
- trace_en  in  1  Capture enable; 0 ignores retirements without counting them as drops.
- flush  in  1  Synchronous clear of the FIFO, seq counter, drop counter and overflow flag.
- retire  in  1  An instruction completes this cycle.
- pc  in  DATA_WIDTH  PC of the retiring instruction.
- pc_next  in  DATA_WIDTH  Next PC selected this cycle.
- instruction  in  DATA_WIDTH  Retiring instruction word.
- RegWrite  in  1  Register file write enable.
- rd  in  5  Destination register.
- WD3  in  DATA_WIDTH  Write-back data.
- MemWrite  in  1  Data memory store enable.
- ALUResult  in  DATA_WIDTH  Store address.
- RD2  in  DATA_WIDTH  Store data.
- trace_valid  out  1  Head record is valid.
- trace_ready  in  1  Consumer accepts the head record.
- trace_seq  out  32  Retirement sequence number.
- trace_pc, trace_pc_next, trace_instr  out  DATA_WIDTH  Captured PC, next PC and instruction word.
- trace_rd_wr  out  1  Architectural register write; 0 when rd==0.
- trace_rd  out  5  Destination register.
- trace_rd_data  out  DATA_WIDTH  Write-back value.
- trace_mem_wr  out  1  Store occurred.
- trace_mem_addr, trace_mem_data  out  DATA_WIDTH  Store address and data.
- level  out  $clog2(DEPTH)+1  Current FIFO occupancy.
- overflow  out  1  Sticky flag: at least one record was dropped.
- drop_cnt  out  CNT_WIDTH  Dropped records; saturates at all-ones.

## Operation
- Push condition: `trace_en & retire` at a rising edge. The record is built combinationally from the inputs in that same cycle.
- Sequence number: `seq` starts at 0. It increments by 1 on every push attempt, accepted or dropped, and wraps modulo 2^32. A gap in `trace_seq` therefore reveals drops.
- `trace_rd_wr = RegWrite & (rd != 0)`. `trace_rd` and `trace_rd_data` are captured unconditionally.
- Pop condition: `trace_valid & trace_ready`.
- Storage: circular buffer with read and write pointers of width $clog2(DEPTH) that wrap naturally, plus an occupancy counter `level`.
- Push acceptance: accepted when `level < DEPTH`, or when `level == DEPTH` and a pop occurs in the same cycle.
  - Otherwise the record is dropped: `overflow` is set, and `drop_cnt` increments unless it is already at all-ones.
- Push and pop in the same cycle leave `level` unchanged.
- `flush` has priority over push and pop in its cycle. Retirement during a flush cycle is discarded and not counted as a drop.
- `trace_*` outputs are driven from the head entry and are stable while `trace_valid & ~trace_ready`.

## Timing
- Reset values: `trace_valid`=0, `level`=0, `overflow`=0, `drop_cnt`=0, `seq`=0, pointers=0. All `trace_*` data outputs are 0 while empty.
- Latency: a record pushed at edge N appears on `trace_valid` after edge N when the FIFO was empty. There is no combinational path from retire inputs to outputs.
- `trace_ready` may be asserted before `trace_valid`. Throughput is one record per cycle.
- Reset asserted mid-stream: all state clears immediately (asynchronous), and in-flight records are lost. Release is taken on a clock edge.
- A full FIFO with a simultaneous retire and pop accepts the new record. Neither `overflow` nor `drop_cnt` changes.

## Configuration
- `MOKA_TRACE_MEM_EN` defined: the store fields `mem_wr`, `mem_addr` and `mem_data` are stored per entry and output as specified.
- `MOKA_TRACE_MEM_EN` undefined: store fields are not stored, which narrows the FIFO width. `trace_mem_wr`, `trace_mem_addr` and `trace_mem_data` are tied to 0. `MemWrite`, `ALUResult` and `RD2` are unused.

## Test plan
- Reset then single retire: pc=0x0, instr=0x00500093, RegWrite=1, rd=1, WD3=5, with `trace_ready`=1 → one cycle later `trace_valid`=1, seq=0, rd_wr=1, rd=1, rd_data=5. The record is then popped and `level` returns to 0.
- Write to x0: RegWrite=1, rd=0 → `trace_rd_wr`=0. Store with MemWrite=1, ALUResult=0x100, RD2=0xDEADBEEF → mem_wr=1, mem_addr=0x100, mem_data=0xDEADBEEF. With the macro off, all three fields read 0.
- Overflow: DEPTH=16, `trace_ready`=0, 20 consecutive retires → `level`=16, `overflow`=1, `drop_cnt`=4. Draining yields seq 0..15, then `trace_valid`=0.
- Full with simultaneous push and pop: `level`=16, retire and pop in the same cycle → `level` stays 16 and `drop_cnt` is unchanged. The next pushed seq follows contiguously.
- Backpressure: `trace_ready` toggled 1010… during 8 retires → head outputs are held stable while not ready, and all 8 records arrive in order with no loss.
- Flush and reset mid-stream: `flush` with `level`=5 plus a simultaneous retire → `level`=0, next seq=0, `drop_cnt`=0. An asynchronous `rst` pulse between edges → `trace_valid` drops immediately.
